// File: rtl/neokeon_round_ctrl_if.sv
// Host-side valid/ready bundle for the NEOKEON round sequencer.
// inDecrypt exists only when NEOKEON_DECRYPT_EN is defined.
interface neokeon_round_ctrl_if;
  logic         inStart;
  logic [127:0] inDataKey;
  logic [127:0] inDataState;
`ifdef NEOKEON_DECRYPT_EN
  logic         inDecrypt;
`endif
  logic         outBusy;
  logic         outValid;
  logic         inReady;
  logic [127:0] outDataState;

  modport master (
    output inStart, inDataKey, inDataState, inReady,
`ifdef NEOKEON_DECRYPT_EN
    output inDecrypt,
`endif
    input  outBusy, outValid, outDataState
  );

  modport slave (
    input  inStart, inDataKey, inDataState, inReady,
`ifdef NEOKEON_DECRYPT_EN
    input  inDecrypt,
`endif
    output outBusy, outValid, outDataState
  );
endinterface

// File: rtl/neokeon_round_ctrl.sv
// Iterative NEOKEON-128 round sequencer; the round function lives outside.
// Optional decryption path (KEYPREP + backward RC) under NEOKEON_DECRYPT_EN.
module neokeon_round_ctrl #(
  parameter int unsigned ROUNDS      = 16,
  parameter logic [7:0]  RC_INIT     = 8'h80
`ifdef NEOKEON_DECRYPT_EN
  ,
  parameter logic [7:0]  RC_DEC_INIT = 8'hD4
`endif
) (
  input  logic                 inClk,
  input  logic                 inRst,
  neokeon_round_ctrl_if.slave  host,
  output logic [127:0]         outRfState,
  output logic [127:0]         outRfKey,
  output logic [7:0]           outRfRc,
  output logic                 outRfFinal,
`ifdef NEOKEON_DECRYPT_EN
  output logic                 outRfDecrypt,
`endif
  input  logic [127:0]         inRfResult
);

  localparam logic [7:0] CNT_LAST = 8'(ROUNDS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_FINAL,
    S_DONE,
    S_KEYPREP
  } state_t;

  state_t       fsm_q;
  logic [127:0] st_q;
  logic [127:0] key_q;
  logic [7:0]   rc_q;
  logic [7:0]   cnt_q;
  logic         busy_q;
  logic         valid_q;
  logic         final_q;

  logic [7:0]   rc_fwd_d;
  logic [7:0]   rc_d;
  logic         last_d;

  assign rc_fwd_d = rc_q[7] ? ({rc_q[6:0], 1'b0} ^ 8'h1B)
                            : {rc_q[6:0], 1'b0};
  assign last_d   = (cnt_q == CNT_LAST);

`ifdef NEOKEON_DECRYPT_EN
  logic       dec_q;
  logic       rfdec_q;
  logic [7:0] rc_bwd_d;
  logic       keyprep_d;

  assign rc_bwd_d  = rc_q[0] ? (((rc_q ^ 8'h1B) >> 1) | 8'h80)
                             : (rc_q >> 1);
  assign rc_d      = dec_q ? rc_bwd_d : rc_fwd_d;
  assign keyprep_d = (fsm_q == S_KEYPREP);

  // KEYPREP reuses the RF as Theta(0,K) to derive the decryption key
  assign outRfState   = keyprep_d ? key_q : st_q;
  assign outRfKey     = keyprep_d ? '0 : key_q;
  assign outRfRc      = keyprep_d ? '0 : rc_q;
  assign outRfDecrypt = rfdec_q;
`else
  assign rc_d       = rc_fwd_d;
  assign outRfState = st_q;
  assign outRfKey   = key_q;
  assign outRfRc    = rc_q;
`endif

  assign outRfFinal        = final_q;
  assign host.outBusy      = busy_q;
  assign host.outValid     = valid_q;
  assign host.outDataState = st_q;

  always_ff @(posedge inClk) begin
    if (inRst) begin
      fsm_q   <= S_IDLE;
      st_q    <= '0;
      key_q   <= '0;
      rc_q    <= RC_INIT;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      final_q <= 1'b0;
`ifdef NEOKEON_DECRYPT_EN
      dec_q   <= 1'b0;
      rfdec_q <= 1'b0;
`endif
    end else begin
      unique case (fsm_q)
        S_IDLE: begin
          if (host.inStart) begin
            st_q   <= host.inDataState;
            key_q  <= host.inDataKey;
            rc_q   <= RC_INIT;
            cnt_q  <= '0;
            busy_q <= 1'b1;
`ifdef NEOKEON_DECRYPT_EN
            dec_q  <= host.inDecrypt;
            if (host.inDecrypt) begin
              fsm_q   <= S_KEYPREP;
              final_q <= 1'b1;
            end else begin
              fsm_q   <= S_RUN;
            end
`else
            fsm_q  <= S_RUN;
`endif
          end
        end
`ifdef NEOKEON_DECRYPT_EN
        S_KEYPREP: begin
          key_q   <= inRfResult;
          rc_q    <= RC_DEC_INIT;
          final_q <= 1'b0;
          rfdec_q <= 1'b1;
          fsm_q   <= S_RUN;
        end
`endif
        S_RUN: begin
          st_q <= inRfResult;
          rc_q <= rc_d;
          if (last_d) begin
            fsm_q   <= S_FINAL;
            final_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        S_FINAL: begin
          st_q    <= inRfResult;
          final_q <= 1'b0;
          valid_q <= 1'b1;
`ifdef NEOKEON_DECRYPT_EN
          rfdec_q <= 1'b0;
`endif
          fsm_q   <= S_DONE;
        end
        S_DONE: begin
          // a new request is only taken once back in IDLE
          if (host.inReady) begin
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            fsm_q   <= S_IDLE;
          end
        end
        default: fsm_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_neokeon_round_ctrl.sv
// Directed bench for neokeon_round_ctrl with a rotate/xor RF stub.
// Decrypt checks compile in only with NEOKEON_DECRYPT_EN.
module tb_neokeon_round_ctrl;

  localparam logic [127:0] KEY  = 128'hb1656851699e29fa24b70148503d2dfc;
  localparam logic [127:0] DATA = 128'h2a78429b87c7d0924f26113f1d1349b2;
  localparam logic [7:0] RC_ENC [0:15] = '{
    8'h80, 8'h1B, 8'h36, 8'h6C, 8'hD8, 8'hAB, 8'h4D, 8'h9A,
    8'h2F, 8'h5E, 8'hBC, 8'h63, 8'hC6, 8'h97, 8'h35, 8'h6A
  };

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [127:0] rf_st;
  logic [127:0] rf_key;
  logic [7:0]   rf_rc;
  logic         rf_fin;
  logic [127:0] rf_res;
  int           n_checks = 0;
  int           n_errors = 0;

  neokeon_round_ctrl_if hif ();

`ifdef NEOKEON_DECRYPT_EN
  logic rf_dec;
`endif

  neokeon_round_ctrl dut (
    .inClk        (clk),
    .inRst        (rst),
    .host         (hif.slave),
    .outRfState   (rf_st),
    .outRfKey     (rf_key),
    .outRfRc      (rf_rc),
    .outRfFinal   (rf_fin),
`ifdef NEOKEON_DECRYPT_EN
    .outRfDecrypt (rf_dec),
`endif
    .inRfResult   (rf_res)
  );

  always #5 clk = ~clk;

  assign rf_res = {rf_st[126:0], rf_st[127]} ^ rf_key ^ {120'b0, rf_rc};

  function automatic logic [127:0] rot(input logic [127:0] s);
    return {s[126:0], s[127]};
  endfunction

  function automatic logic [127:0] enc_model(input logic [127:0] k,
                                             input logic [127:0] d);
    logic [127:0] s;
    s = d;
    for (int i = 0; i < 16; i++) s = rot(s) ^ k ^ {120'b0, RC_ENC[i]};
    return rot(s) ^ k ^ {120'b0, 8'hD4};
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs,
                     input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h want=%h", tag, obs, exp);
    end
  endtask

  task automatic start_op(input logic [127:0] k, input logic [127:0] d);
    hif.inDataKey   = k;
    hif.inDataState = d;
    hif.inStart     = 1'b1;
    @(negedge clk);
    hif.inStart     = 1'b0;
  endtask

  task automatic wait_valid();
    int n;
    n = 0;
    while (!hif.outValid && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("vtimeout", 128'(hif.outValid), 128'(1));
  endtask

  task automatic release_result();
    hif.inReady = 1'b1;
    @(negedge clk);
    hif.inReady = 1'b0;
    chk("rel_busy", 128'(hif.outBusy), 128'(0));
  endtask

  initial begin
    logic [127:0] exp;
    int t [0:7];
    int na;
    int seen;
    logic pbusy;

    hif.inStart     = 1'b0;
    hif.inReady     = 1'b0;
    hif.inDataKey   = '0;
    hif.inDataState = '0;
`ifdef NEOKEON_DECRYPT_EN
    hif.inDecrypt   = 1'b0;
`endif
    exp = enc_model(KEY, DATA);

    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("rst_busy", 128'(hif.outBusy), 128'(0));
      chk("rst_valid", 128'(hif.outValid), 128'(0));
      chk("rst_rc", 128'(rf_rc), 128'(8'h80));
    end
    chk("rst_data", hif.outDataState, 128'(0));

    // encrypt with RC log
    start_op(KEY, DATA);
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("rc%0d", i), 128'(rf_rc), 128'(RC_ENC[i]));
      chk("run_fin", 128'(rf_fin), 128'(0));
      chk("run_valid", 128'(hif.outValid), 128'(0));
      @(negedge clk);
    end
    chk("rc_final", 128'(rf_rc), 128'(8'hD4));
    chk("fin_flag", 128'(rf_fin), 128'(1));
    chk("fin_valid", 128'(hif.outValid), 128'(0));
    @(negedge clk);
    chk("lat17_valid", 128'(hif.outValid), 128'(1));
    chk("enc_data", hif.outDataState, exp);

    // hold in DONE, with a stray start
    for (int i = 0; i < 10; i++) begin
      hif.inStart     = (i == 4);
      hif.inDataState = (i == 4) ? ~DATA : DATA;
      @(negedge clk);
      chk("hold_valid", 128'(hif.outValid), 128'(1));
      chk("hold_data", hif.outDataState, exp);
    end
    hif.inStart = 1'b1;
    hif.inReady = 1'b1;
    @(negedge clk);
    hif.inStart = 1'b0;
    hif.inReady = 1'b0;
    chk("done_idle_busy", 128'(hif.outBusy), 128'(0));
    chk("done_idle_valid", 128'(hif.outValid), 128'(0));
    @(negedge clk);
    chk("start_in_done_ignored", 128'(hif.outBusy), 128'(0));

    // start mid-run ignored
    start_op(KEY, DATA);
    repeat (5) @(negedge clk);
    start_op(~KEY, 128'h0123456789abcdef0011223344556677);
    wait_valid();
    chk("midstart_data", hif.outDataState, exp);
    release_result();

    // reset abort at cnt 8
    start_op(KEY, DATA);
    repeat (8) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy", 128'(hif.outBusy), 128'(0));
    chk("abort_valid", 128'(hif.outValid), 128'(0));
    chk("abort_rc", 128'(rf_rc), 128'(8'h80));
    chk("abort_data", hif.outDataState, 128'(0));
    seen = 0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (hif.outValid) seen++;
    end
    chk("abort_novalid", 128'(seen), 128'(0));

    // back-to-back
    hif.inDataKey   = KEY;
    hif.inDataState = DATA;
    hif.inStart     = 1'b1;
    hif.inReady     = 1'b1;
    na    = 0;
    pbusy = hif.outBusy;
    for (int c = 0; c < 80; c++) begin
      @(negedge clk);
      if (hif.outBusy && !pbusy && na < 8) begin
        t[na] = c;
        na++;
      end
      pbusy = hif.outBusy;
    end
    hif.inStart = 1'b0;
    chk("b2b_accepts", 128'(na >= 3), 128'(1));
    if (na >= 3) begin
      chk("b2b_period1", 128'(t[1] - t[0]), 128'(19));
      chk("b2b_period2", 128'(t[2] - t[1]), 128'(19));
    end
    repeat (25) @(negedge clk);
    hif.inReady = 1'b0;
    chk("b2b_drain", 128'(hif.outBusy), 128'(0));

`ifdef NEOKEON_DECRYPT_EN
    begin
      logic [127:0] k2;
      logic [127:0] s;
      logic [7:0]   r;
      k2 = rot(KEY);
      s  = DATA;
      for (int i = 0; i < 16; i++) begin
        r = (i == 0) ? 8'hD4 : RC_ENC[16 - i];
        s = rot(s) ^ k2 ^ {120'b0, r};
      end
      s = rot(s) ^ k2 ^ {120'b0, 8'h80};
      hif.inDecrypt = 1'b1;
      start_op(KEY, DATA);
      hif.inDecrypt = 1'b0;
      chk("kp_key", rf_key, 128'(0));
      chk("kp_state", rf_st, KEY);
      chk("kp_fin", 128'(rf_fin), 128'(1));
      chk("kp_rc", 128'(rf_rc), 128'(0));
      @(negedge clk);
      for (int i = 0; i < 16; i++) begin
        r = (i == 0) ? 8'hD4 : RC_ENC[16 - i];
        chk($sformatf("drc%0d", i), 128'(rf_rc), 128'(r));
        chk("d_rfdec", 128'(rf_dec), 128'(1));
        @(negedge clk);
      end
      chk("drc_final", 128'(rf_rc), 128'(8'h80));
      chk("d_fin", 128'(rf_fin), 128'(1));
      chk("d_valid_early", 128'(hif.outValid), 128'(0));
      @(negedge clk);
      chk("lat18_valid", 128'(hif.outValid), 128'(1));
      chk("dec_data", hif.outDataState, s);
      release_result();
    end
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
